// File: rtl/mdio_pkg.sv
// MDIO management frame layout and controller state encoding,
// shared by the MDIO initiator and receiver.
package mdio_pkg;

  localparam int ST_HI      = 31;
  localparam int OP_HI      = 29;
  localparam int PHY_HI     = 27;
  localparam int REG_HI     = 22;
  localparam int TA_HI      = 17;
  localparam int DATA_HI    = 15;
  localparam int FRAME_BITS = 32;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/mdio_mdc_gen.sv
// MDC divider: toggles every HALF_PER clocks while enabled and
// flags the clock edges on which MDC is about to rise or fall.
module mdio_mdc_gen #(
  parameter int HALF_PER = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic mdc,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(HALF_PER) + 1;

  logic [CW-1:0] cnt;
  logic          tick;

  assign tick = en && (cnt == CW'(HALF_PER - 1));
  assign rise = tick && !mdc;
  assign fall = tick && mdc;

  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (tick) begin
      cnt <= '0;
      mdc <= ~mdc;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/controlador_mdio.sv
// MDIO station-management initiator: serialises a 32-bit frame on
// MDIO with a generated MDC and captures read data from the PHY.
module controlador_mdio
  import mdio_pkg::*;
#(
  parameter int HALF_PER = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MDIO_START,
  input  logic [31:0] T_DATA,
  input  logic        MDIO_IN,
  output logic        MDC,
  output logic        MDIO_OUT,
  output logic        MDIO_OE,
  output logic        MDIO_DONE,
  output logic [15:0] RD_DATA,
  output logic        DATA_RDY
);

  state_t      state;
  state_t      nxt;
  logic [5:0]  bit_cnt;
  logic [31:0] sr;
  logic [15:0] rx;
  logic        rd;
  logic        rise;
  logic        fall;
  logic        last;
  logic        nxt_out;
  logic        nxt_oe;
  logic        nxt_done;
  logic        nxt_rdy;

  mdio_mdc_gen #(
    .HALF_PER(HALF_PER)
  ) u_mdc (
    .clk  (CLK),
    .rst_n(RESET),
    .en   (state == SHIFT),
    .mdc  (MDC),
    .rise (rise),
    .fall (fall)
  );

  assign last = fall && (bit_cnt == 6'(FRAME_BITS - 1));

  always_ff @(posedge CLK) begin
    if (!RESET) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (MDIO_START) nxt = SHIFT;
      SHIFT:   if (last) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    nxt_out  = MDIO_OUT;
    nxt_oe   = MDIO_OE;
    nxt_done = 1'b0;
    nxt_rdy  = 1'b0;
    unique case (state)
      IDLE: begin
        nxt_out = MDIO_START && T_DATA[ST_HI];
        nxt_oe  = MDIO_START;
      end
      SHIFT: begin
        if (last) begin
          nxt_out  = 1'b0;
          nxt_oe   = 1'b0;
          nxt_done = 1'b1;
          nxt_rdy  = rd;
        end else if (fall) begin
          nxt_oe  = !rd || (bit_cnt < 6'd15);
          nxt_out = nxt_oe && sr[FRAME_BITS-2];
        end
      end
      default: begin
        nxt_out = 1'b0;
        nxt_oe  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      MDIO_OUT  <= 1'b0;
      MDIO_OE   <= 1'b0;
      MDIO_DONE <= 1'b0;
      DATA_RDY  <= 1'b0;
      RD_DATA   <= '0;
      bit_cnt   <= '0;
      sr        <= '0;
      rx        <= '0;
      rd        <= 1'b0;
    end else begin
      MDIO_OUT  <= nxt_out;
      MDIO_OE   <= nxt_oe;
      MDIO_DONE <= nxt_done;
      DATA_RDY  <= nxt_rdy;
      if (state == IDLE) begin
        bit_cnt <= '0;
        if (MDIO_START) begin
          sr <= T_DATA;
          rd <= (T_DATA[OP_HI -: 2] == OP_READ);
          rx <= '0;
        end
      end
      if (state == SHIFT && fall) begin
        sr      <= {sr[FRAME_BITS-2:0], 1'b0};
        bit_cnt <= bit_cnt + 6'd1;
      end
      // The PHY's data half is sampled as MDC rises.
      if (state == SHIFT && rise && rd && bit_cnt >= 6'd16)
        rx <= {rx[14:0], MDIO_IN};
      if (last && rd)
        RD_DATA <= rx;
    end
  end

endmodule

// File: tb/tb_controlador_mdio.sv
// Bench for controlador_mdio: two instances (HALF_PER 1 and 3) share
// stimulus and are checked every cycle against a timing-formula model.
module tb_controlador_mdio;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        START = 1'b0;
  logic [31:0] T_DATA = '0;
  logic        in1 = 1'b0;
  logic        in3 = 1'b0;
  logic        mdc1, out1, oe1, done1, rdy1;
  logic        mdc3, out3, oe3, done3, rdy3;
  logic [15:0] rd1, rd3;
  logic [20:0] o1, o3;

  assign o1 = {mdc1, out1, oe1, done1, rdy1, rd1};
  assign o3 = {mdc3, out3, oe3, done3, rdy3, rd3};

  controlador_mdio #(.HALF_PER(1)) u1 (
    .CLK(CLK), .RESET(RESET), .MDIO_START(START), .T_DATA(T_DATA),
    .MDIO_IN(in1), .MDC(mdc1), .MDIO_OUT(out1), .MDIO_OE(oe1),
    .MDIO_DONE(done1), .RD_DATA(rd1), .DATA_RDY(rdy1)
  );

  controlador_mdio #(.HALF_PER(3)) u3 (
    .CLK(CLK), .RESET(RESET), .MDIO_START(START), .T_DATA(T_DATA),
    .MDIO_IN(in3), .MDC(mdc3), .MDIO_OUT(out3), .MDIO_OE(oe3),
    .MDIO_DONE(done3), .RD_DATA(rd3), .DATA_RDY(rdy3)
  );

  always #5 CLK = ~CLK;

  int hp [2] = '{1, 3};
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic armed = 1'b0;
  logic [15:0] phy_val = '0;

  logic        m_act [2] = '{1'b0, 1'b0};
  int          m_k   [2] = '{0, 0};
  logic [31:0] m_fr  [2];
  logic        m_rd  [2] = '{1'b0, 1'b0};
  logic [15:0] m_phy [2];
  logic [15:0] m_rdd [2] = '{16'h0, 16'h0};

  int          dn [2] = '{0, 0};
  int          rdy_n [2] = '{0, 0};
  int          rdy_at [2] = '{0, 0};
  int          last_done [2] = '{0, 0};
  logic        pmdc [2] = '{1'b0, 1'b0};
  logic [31:0] cap [2];
  logic [31:0] ocap [2];
  logic [31:0] cap_snap [2];
  logic [31:0] oe_snap [2];
  int          dq0 [$];

  // Transaction model: a frame occupies 64*HALF_PER cycles after its
  // start edge, then one DONE cycle, then one cycle back in idle.
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (!RESET) armed <= 1'b1;
    for (int d = 0; d < 2; d++) begin
      if (!RESET) begin
        m_act[d] <= 1'b0;
        m_rdd[d] <= '0;
      end else if (m_act[d]) begin
        if (m_k[d] >= 64 * hp[d]) m_act[d] <= 1'b0;
        else m_k[d] <= m_k[d] + 1;
        if (m_k[d] + 1 == 64 * hp[d] && m_rd[d]) m_rdd[d] <= m_phy[d];
      end else if (START) begin
        m_act[d] <= 1'b1;
        m_k[d]   <= 0;
        m_fr[d]  <= T_DATA;
        m_rd[d]  <= (T_DATA[29:28] == 2'b10);
        m_phy[d] <= phy_val;
      end
    end
  end

  function automatic logic [20:0] exp_out(int d);
    int k, h, i;
    logic mdc, oe, out;
    if (!m_act[d]) return {5'b0, m_rdd[d]};
    k = m_k[d];
    h = hp[d];
    if (k == 64 * h) return {3'b000, 1'b1, m_rd[d], m_rdd[d]};
    i   = k / (2 * h);
    mdc = (k % (2 * h)) >= h;
    oe  = !m_rd[d] || i < 16;
    out = oe && m_fr[d][31-i];
    return {mdc, out, oe, 2'b00, m_rdd[d]};
  endfunction

  // PHY: answers the data half of a read frame, noise otherwise.
  always @(negedge CLK) begin
    for (int d = 0; d < 2; d++) begin
      logic b;
      int i;
      b = 1'($urandom);
      if (m_act[d] && m_rd[d] && m_k[d] < 64 * hp[d]) begin
        i = m_k[d] / (2 * hp[d]);
        if (i >= 16) b = m_phy[d][31-i];
      end
      if (d == 0) in1 = b;
      else        in3 = b;
    end
  end

  always @(negedge CLK) begin : cmp
    logic [20:0] a, e;
    if (armed) begin
      for (int d = 0; d < 2; d++) begin
        a = (d == 0) ? o1 : o3;
        e = exp_out(d);
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs_u%0d cycle %0d: got %h expected %h",
                   d, cyc, a, e);
        end
        if (a[20] && !pmdc[d]) begin
          cap[d]  = {cap[d][30:0], a[19]};
          ocap[d] = {ocap[d][30:0], a[18]};
        end
        pmdc[d] = a[20];
        if (a[17]) begin
          dn[d]++;
          last_done[d] = cyc;
          cap_snap[d]  = cap[d];
          oe_snap[d]   = ocap[d];
          if (d == 0) dq0.push_back(cyc);
        end
        if (a[16]) begin
          rdy_n[d]++;
          rdy_at[d] = cyc;
        end
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_start(logic [31:0] d, output int t0);
    T_DATA = d;
    START  = 1'b1;
    tick(1);
    t0    = cyc;
    START = 1'b0;
  endtask

  task automatic wait_done(int d, int target, int budget);
    int b;
    b = 0;
    while (dn[d] < target && b < budget) begin
      tick(1);
      b++;
    end
    checks++;
    if (dn[d] < target) begin
      errors++;
      $display("FAIL wait_done_u%0d: got %0d dones expected %0d",
               d, dn[d], target);
    end
  endtask

  initial begin
    int t0, n0, n1, r0, r1;
    tick(3);
    RESET = 1'b1;
    tick(2);
    check("reset_u1", 32'(o1), 32'h0);
    check("reset_u3", 32'(o3), 32'h0);

    // Write frame on both dividers at once.
    n0 = dn[0];
    n1 = dn[1];
    pulse_start(32'h508AABCD, t0);
    wait_done(1, n1 + 1, 400);
    check("t1_bits", cap_snap[0], 32'h508AABCD);
    check("t1_oe", oe_snap[0], 32'hFFFFFFFF);
    check("t1_latency", 32'(last_done[0] - t0), 32'd64);
    check("t1_dones", 32'(dn[0] - n0), 32'd1);
    check("t1_rdy", 32'(rdy_n[0]), 32'd0);
    check("t1_rd_data", 32'(rd1), 32'h0);
    check("t3_bits", cap_snap[1], 32'h508AABCD);
    check("t3_latency", 32'(last_done[1] - t0), 32'd192);
    tick(2);

    // Read abandoned by reset at t0+20.
    phy_val = 16'h5A5A;
    n0 = dn[0];
    n1 = dn[1];
    pulse_start(32'h608A0000, t0);
    tick(19);
    RESET = 1'b0;
    tick(1);
    RESET = 1'b1;
    check("t4_zero_u1", 32'(o1), 32'h0);
    check("t4_zero_u3", 32'(o3), 32'h0);
    tick(300);
    check("t4_no_done_u1", 32'(dn[0] - n0), 32'd0);
    check("t4_no_done_u3", 32'(dn[1] - n1), 32'd0);

    // Read frame with the PHY returning 0x1234.
    phy_val = 16'h1234;
    n1 = dn[1];
    pulse_start(32'h608A0000, t0);
    wait_done(1, n1 + 1, 400);
    check("t2_rd_u1", 32'(rd1), 32'h1234);
    check("t2_rd_u3", 32'(rd3), 32'h1234);
    check("t2_oe", oe_snap[0], 32'hFFFF0000);
    check("t2_latency", 32'(last_done[0] - t0), 32'd64);
    check("t2_rdy_cycle", 32'(rdy_at[0]), 32'(last_done[0]));
    tick(2);

    // A start pulse mid-write is ignored; T_DATA change has no effect.
    n0 = dn[0];
    n1 = dn[1];
    pulse_start(32'h508AABCD, t0);
    tick(29);
    T_DATA = 32'h608A0000;
    START  = 1'b1;
    tick(1);
    START = 1'b0;
    wait_done(1, n1 + 1, 400);
    tick(5);
    check("t5_single_u1", 32'(dn[0] - n0), 32'd1);
    check("t5_single_u3", 32'(dn[1] - n1), 32'd1);
    check("t5_latched", cap_snap[0], 32'h508AABCD);

    // START held high across DONE.
    n0 = dn[0];
    T_DATA = 32'h508AABCD;
    START  = 1'b1;
    wait_done(0, n0 + 2, 300);
    START = 1'b0;
    if (dq0.size() >= 2)
      check("t5_gap", 32'(dq0[$] - dq0[$-1]), 32'd66);
    tick(400);

    // OP=11 behaves as a write.
    r0 = rdy_n[0];
    r1 = rdy_n[1];
    n1 = dn[1];
    pulse_start(32'h708AFFFF, t0);
    wait_done(1, n1 + 1, 400);
    check("t6_oe", oe_snap[0], 32'hFFFFFFFF);
    check("t6_bits", cap_snap[0], 32'h708AFFFF);
    check("t6_no_rdy_u1", 32'(rdy_n[0] - r0), 32'd0);
    check("t6_no_rdy_u3", 32'(rdy_n[1] - r1), 32'd0);
    tick(2);

    // Random frames, start timing and occasional resets.
    for (int it = 0; it < 25; it++) begin
      T_DATA  = $urandom;
      phy_val = 16'($urandom);
      START   = 1'b1;
      tick(int'($urandom_range(1, 3)));
      START  = 1'b0;
      T_DATA = $urandom;
      if ($urandom_range(0, 5) == 0) begin
        tick(int'($urandom_range(1, 150)));
        RESET = 1'b0;
        tick(1);
        RESET = 1'b1;
      end
      tick(int'($urandom_range(0, 250)));
    end
    tick(400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/controlador_mdio.md
Name: controlador_mdio

Overview:
- MDIO station-management controller: the initiator side of the MDIO link that receptor_mdio answers.
- Takes a 32-bit management frame in parallel and serialises it MSB-first on MDIO_OUT, together with the MDC clock it generates.
- For read frames, releases the line and shifts the PHY's 16 data bits from MDIO_IN into RD_DATA.
- Signals completion with MDIO_DONE, the input receptor_mdio consumes.

Parameters:
HALF_PER, 1, CLK cycles per MDC half-period (MDC = CLK/(2*HALF_PER)); legal values >= 1.

Ports:
CLK  input  1  system clock; all logic on rising edge.
RESET  input  1  synchronous, active-low reset.
MDIO_START  input  1  request; sampled only in IDLE.
T_DATA  input  32  frame: [31:30] ST, [29:28] OP, [27:23] PHY addr, [22:18] REG addr, [17:16] TA, [15:0] data.
MDIO_IN  input  1  serial data from PHY (read data phase).
MDC  output  1  management clock; low when idle.
MDIO_OUT  output  1  serial frame bit.
MDIO_OE  output  1  1 = controller drives MDIO.
MDIO_DONE  output  1  one-CLK pulse at end of every transaction.
RD_DATA  output  16  last read result.
DATA_RDY  output  1  one-CLK pulse when RD_DATA updated by a read.

Behaviour:
- Reset (RESET=0 at a CLK edge):
  - All outputs become 0: MDC, MDIO_OUT, MDIO_OE, MDIO_DONE, RD_DATA, DATA_RDY.
  - State returns to IDLE; counters and shift registers clear.
  - Applies mid-transaction too; the frame is abandoned and no DONE is issued.
- States:
  - IDLE -> SHIFT when MDIO_START=1 at edge t0.
  - SHIFT -> DONE after 32 bits.
  - DONE -> IDLE unconditionally after one cycle.
  - MDIO_START is ignored outside IDLE.
- Frame latch: T_DATA is captured at t0 into a shift register. Later T_DATA changes have no effect.
- Read detection: OP = T_DATA[29:28] = 2'b10 is a read. Every other OP value is a write; 00 and 11 are treated as writes, with no error flag.
- Bit timing, for bit index i = 0..31 (i=0 is T_DATA[31]):
  - MDIO_OUT is presented at edge t0+2*HALF_PER*i with MDC=0.
  - MDC rises at t0+2*HALF_PER*i+HALF_PER; the PHY samples on this rise.
  - MDC falls at t0+2*HALF_PER*(i+1), and the next bit is presented on that same edge.
- MDIO_OE:
  - Write: 1 for all 32 bits.
  - Read: 1 for bits i=0..15 (ST, OP, PHY, REG, TA as supplied in T_DATA), 0 for i=16..31.
  - While OE=0, MDIO_OUT is held at 0.
- Read capture:
  - For i=16..31, MDIO_IN is sampled on the CLK edge where MDC goes 0->1 and shifted into an internal 16-bit register, MSB first.
  - RD_DATA updates only at completion, never partially. Writes leave RD_DATA unchanged.
- Completion, at edge t0+64*HALF_PER (state DONE):
  - MDC=0, MDIO_OE=0, MDIO_OUT=0.
  - MDIO_DONE=1 for exactly one cycle.
  - Read only: RD_DATA loaded and DATA_RDY=1 for the same cycle.
- Back-to-back: a START held high is accepted again in IDLE, one cycle after DONE. The minimum gap between frames is therefore 2 CLK cycles.
- Counters:
  - Bit counter is 6 bits (0..32).
  - Divider counter is $clog2(HALF_PER)+1 bits; it resets to 0 on every MDC toggle and holds 0 outside SHIFT.
- All outputs are registered; there are no combinational paths from input to output.

Decomposition:
- Shared package mdio_pkg holds:
  - Field position constants: ST_HI=31, OP_HI=29, PHY_HI=27, REG_HI=22, TA_HI=17, DATA_HI=15.
  - OP_WRITE=2'b01, OP_READ=2'b10, FRAME_BITS=32.
  - State encodings IDLE/SHIFT/DONE.
- The package is shared with receptor_mdio.
- One sub-module, mdio_mdc_gen:
  - Parameterised by HALF_PER; enable and synchronous active-low reset.
  - Outputs MDC, plus one-cycle rise/fall strobes used by the shifter and the read sampler.

Test Plan:
1. Write, HALF_PER=1, T_DATA=0x508AABCD:
   - MDIO_OUT sequence on MDC rises equals 0x508AABCD MSB-first, with MDIO_OE=1 for all 32 bits.
   - MDIO_DONE pulses at t0+64; DATA_RDY stays 0 and RD_DATA stays 0x0000.
2. Read, T_DATA=0x608A0000, PHY model drives 0x1234 on bits 16..31:
   - MDIO_OE=1 for 16 bits, then 0.
   - At t0+64, RD_DATA=0x1234 with DATA_RDY and MDIO_DONE both pulsing one cycle.
3. HALF_PER=3 write of 0x508AABCD: MDC period is 6 CLK and MDIO_DONE arrives at t0+192. The bit sequence is identical to case 1.
4. RESET=0 at t0+20 during a read:
   - Next edge: all outputs are 0 and the state is IDLE.
   - No MDIO_DONE; RD_DATA keeps its prior value 0.
   - A new START afterwards completes normally.
5. Second START pulse (0x608A0000) asserted mid-write: ignored, so only one MDIO_DONE occurs. START held high over DONE: the next frame begins 2 cycles after the MDIO_DONE pulse.
6. OP=2'b11 (T_DATA=0x708AFFFF): treated as a write; OE=1 for all 32 bits and DATA_RDY never asserts.
